// File: rtl/shift_add_mult_8b_pkg.sv
// Shared constants and state encoding for the 8x8 shift-add multiplier.
package shift_add_mult_8b_pkg;

  localparam int OP_W       = 8;
  localparam int PROD_W     = 16;
  localparam int MULT_STEPS = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mult_8b_adder.sv
// 8-bit ripple-carry adder assembled from 1-bit full-adder cells.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module ripple_adder_8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic       carry,
  output logic [7:0] sum
);

  logic [8:0] c;

  assign c[0]  = cin;
  assign carry = c[8];

  for (genvar i = 0; i < 8; i++) begin : g_cell
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

endmodule

// File: rtl/shift_add_mult_8b.sv
// Sequential unsigned 8x8->16 multiplier: one add/shift step per clock through
// a shared ripple adder, with a start/ready/done handshake.
module shift_add_mult_8b
  import shift_add_mult_8b_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OP_W-1:0]     a,
  input  logic [OP_W-1:0]     b,
  output logic                ready,
  output logic                done,
  output logic [PROD_W-1:0]   product
);

  state_t             state;
  logic [OP_W-1:0]    mcand;
  logic [OP_W-1:0]    acc;
  logic [OP_W-1:0]    mq;
  logic               cout;
  logic [CNT_W-1:0]   cnt;

  logic [OP_W-1:0]    sum;
  logic               carry;
  logic [2*OP_W+1:0]  step_w;

  ripple_adder_8b u_adder (
    .a    (acc),
    .b    (mcand),
    .cin  (1'b0),
    .carry(carry),
    .sum  (sum)
  );

  // {cout, acc, mq} with a leading zero, before the right shift. cout is
  // always zero after a shift, so the no-add path still yields a zero MSB.
  assign step_w = mq[0] ? {1'b0, carry, sum, mq} : {1'b0, cout, acc, mq};

  // NOTE: all state uses non-blocking assignment so every register samples
  // the pre-edge values; the product register is a separate copy so it only
  // moves on iteration edges, never on the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      mq      <= '0;
      cout    <= 1'b0;
      cnt     <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            mq    <= b;
            acc   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          {cout, acc, mq} <= step_w[2*OP_W+1:1];
          product         <= step_w[2*OP_W:1];
          cnt             <= cnt + 1'b1;
          if (cnt == CNT_W'(MULT_STEPS - 1)) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_8b.sv
// Directed and swept checks of shift_add_mult_8b: latency, handshake, held
// result, start-ignore, mid-run reset and back-to-back throughput.
module tb_shift_add_mult_8b;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready;
  logic        done;
  logic [15:0] product;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  shift_add_mult_8b dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete handshake: accept, latency, single done pulse, held result.
  task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic [15:0] exp, input string tag);
    int n;
    bit seen;
    @(negedge clk);
    a = op_a;
    b = op_b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~op_a;
    b = ~op_b;
    check({tag, "_ready_low"}, ready, 0);
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        n = i;
        break;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      check({tag, "_latency"}, n, 9);
      check({tag, "_product"}, product, exp);
      check({tag, "_ready_in_done"}, ready, 0);
      @(negedge clk);
      check({tag, "_done_single"}, done, 0);
      check({tag, "_ready_back"}, ready, 1);
      check({tag, "_product_held"}, product, exp);
    end
  endtask

  typedef struct { logic [7:0] a; logic [7:0] b; } pair_t;

  initial begin
    pair_t pairs [6];
    int base;
    int last_t;
    int t;
    bit seen;
    logic [7:0] ra;
    logic [7:0] rb;

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_ready", ready, 1);
    check("reset_done", done, 0);
    check("reset_product", product, 16'h0000);

    run_op(8'd13, 8'd11, 16'h008F, "m13x11");
    run_op(8'd255, 8'd255, 16'hFE01, "m255x255");
    run_op(8'd0, 8'd200, 16'h0000, "m0x200");
    run_op(8'd1, 8'd255, 16'h00FF, "m1x255");

    // start held during RUN and DONE with new operands must be ignored.
    base = done_cnt;
    @(negedge clk);
    a = 8'd3; b = 8'd5; start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'd9; b = 8'd9;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    start = 1'b0;
    check("ign_done_seen", seen, 1);
    check("ign_product", product, 16'h000F);
    repeat (4) @(negedge clk);
    check("ign_one_done", done_cnt - base, 1);
    check("ign_product_held", product, 16'h000F);
    check("ign_ready", ready, 1);

    // Reset sampled on E4 of a 100x100 operation.
    @(negedge clk);
    a = 8'd100; b = 8'd100; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    base = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_ready", ready, 1);
    check("rst_product", product, 16'h0000);
    check("rst_done", done, 0);
    repeat (12) @(negedge clk);
    check("rst_no_done", done_cnt - base, 0);
    check("rst_product_stays", product, 16'h0000);
    run_op(8'd100, 8'd100, 16'h2710, "m100x100");

    // Back-to-back with start held high: one operation per 10 cycles.
    pairs[0] = '{8'd7,   8'd6};
    pairs[1] = '{8'd200, 8'd3};
    pairs[2] = '{8'd7,   8'd6};
    pairs[3] = '{8'd200, 8'd3};
    pairs[4] = '{8'd17,  8'd15};
    pairs[5] = '{8'd128, 8'd2};
    @(negedge clk);
    a = pairs[0].a; b = pairs[0].b; start = 1'b1;
    t = 0;
    last_t = 0;
    for (int k = 0; k < 6; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        t++;
        if (done) begin seen = 1'b1; break; end
      end
      check("b2b_done_seen", seen, 1);
      if (!seen) break;
      if (k > 0) check("b2b_period", t - last_t, 10);
      last_t = t;
      check("b2b_product", product, 32'(pairs[k].a) * 32'(pairs[k].b));
      if (k < 5) begin
        a = pairs[k+1].a;
        b = pairs[k+1].b;
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Swept operands against the arithmetic reference, corners included.
    for (int k = 0; k < 1000; k++) begin
      case (k)
        0:       begin ra = 8'h00; rb = 8'h00; end
        1:       begin ra = 8'hFF; rb = 8'hFF; end
        2:       begin ra = 8'hFF; rb = 8'h00; end
        3:       begin ra = 8'h00; rb = 8'hFF; end
        default: begin ra = 8'($urandom_range(255)); rb = 8'($urandom_range(255)); end
      endcase
      run_op(ra, rb, 16'(ra) * 16'(rb), "sweep");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
